frame_color_classifier: RTL and testbench

- Downstream consumer of the frame buffer's read port.
- Watches the pixel stream the VGA scan fetches from the M9K buffer (RGB332) over the 176x144 camera window.
- Counts red-dominant and blue-dominant pixels per frame and classifies the frame at each VSYNC as NONE, RED or BLUE.
- Feeds the treasure/colour decision to the robot controller over GPIO.

---
 rtl/frame_color_classifier.sv | 203 ++++++++++++++++++++
 tb/tb_frame_color_classifier.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_color_classifier.sv
`default_nettype none
// ============================================================================
// Module      : frame_color_classifier
// Description : Counts red- and blue-dominant RGB332 pixels in the camera
//               window of the VGA read stream and classifies each frame at
//               the VSYNC falling edge. Optional macro FRAME_VOTE_EN adds a
//               multi-frame vote before RESULT is allowed to change.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_color_classifier #(
    parameter int          SCREEN_WIDTH  = 176,
    parameter int          SCREEN_HEIGHT = 144,
    parameter logic [2:0]  RED_MIN       = 3'd5,
    parameter logic [1:0]  BLUE_MIN      = 2'd2,
    parameter logic [2:0]  G_MAX         = 3'd2,
    parameter logic [14:0] RED_THRESH    = 15'd2000,
`ifdef FRAME_VOTE_EN
    parameter int          VOTE_FRAMES   = 3,
`endif
    parameter logic [14:0] BLUE_THRESH   = 15'd2000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  PIXEL_IN,
    input  logic [9:0]  VGA_PIXEL_X,
    input  logic [9:0]  VGA_PIXEL_Y,
    input  logic        VGA_VSYNC_NEG,
    output logic [1:0]  RESULT,
    output logic        RESULT_VALID,
    output logic [14:0] RED_COUNT,
    output logic [14:0] BLUE_COUNT,
    output logic        FRAME_DONE
);

    localparam logic [1:0]  c_WAIT_FRAME = 2'd0;
    localparam logic [1:0]  c_ACCUM      = 2'd1;
    localparam logic [1:0]  c_DECIDE     = 2'd2;

    localparam logic [1:0]  c_RES_NONE   = 2'b00;
    localparam logic [1:0]  c_RES_RED    = 2'b01;
    localparam logic [1:0]  c_RES_BLUE   = 2'b10;

    localparam logic [9:0]  c_WIDTH      = 10'(SCREEN_WIDTH);
    localparam logic [9:0]  c_HEIGHT     = 10'(SCREEN_HEIGHT);
    localparam logic [14:0] c_ACC_MAX    = 15'h7FFF;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [9:0]  r_x;
    logic [9:0]  r_y;
    logic        r_vsync;
    logic        w_vsync_fall;
    logic        w_in_window;
    logic        w_is_red;
    logic        w_is_blue;
    logic [14:0] r_red_acc;
    logic [14:0] r_blue_acc;
    logic [14:0] w_red_next;
    logic [14:0] w_blue_next;
    logic [14:0] r_red_snap;
    logic [14:0] r_blue_snap;
    logic [1:0]  w_decision;

    // The frame buffer answers one cycle after the address, so the scan
    // position is delayed once to line up with PIXEL_IN.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_x     <= '0;
            r_y     <= '0;
            r_vsync <= 1'b0;
        end else begin
            r_x     <= VGA_PIXEL_X;
            r_y     <= VGA_PIXEL_Y;
            r_vsync <= VGA_VSYNC_NEG;
        end
    end

    always_comb begin
        w_vsync_fall = r_vsync & ~VGA_VSYNC_NEG;
        w_in_window  = (r_x < c_WIDTH) && (r_y < c_HEIGHT);
        w_is_red     = w_in_window
                       && (PIXEL_IN[7:5] >= RED_MIN)
                       && (PIXEL_IN[4:2] <= G_MAX)
                       && (PIXEL_IN[1:0] == 2'd0);
        w_is_blue    = w_in_window
                       && (PIXEL_IN[1:0] >= BLUE_MIN)
                       && (PIXEL_IN[4:2] <= G_MAX)
                       && (PIXEL_IN[7:5] <= 3'd2);
        w_red_next   = (w_is_red && (r_red_acc != c_ACC_MAX))
                       ? r_red_acc + 15'd1 : r_red_acc;
        w_blue_next  = (w_is_blue && (r_blue_acc != c_ACC_MAX))
                       ? r_blue_acc + 15'd1 : r_blue_acc;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= c_WAIT_FRAME;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_WAIT_FRAME: if (w_vsync_fall) w_state_next = c_ACCUM;
            c_ACCUM:      if (w_vsync_fall) w_state_next = c_DECIDE;
            c_DECIDE:     w_state_next = c_ACCUM;
            default:      w_state_next = c_WAIT_FRAME;
        endcase
    end

    // The snapshot takes the incremented value so a pixel landing on the
    // edge cycle still belongs to the frame that is ending.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_red_acc   <= '0;
            r_blue_acc  <= '0;
            r_red_snap  <= '0;
            r_blue_snap <= '0;
        end else if (r_state == c_ACCUM) begin
            r_red_acc  <= w_red_next;
            r_blue_acc <= w_blue_next;
            if (w_vsync_fall) begin
                r_red_snap  <= w_red_next;
                r_blue_snap <= w_blue_next;
            end
        end else begin
            r_red_acc  <= '0;
            r_blue_acc <= '0;
        end
    end

    always_comb begin
        w_decision = c_RES_NONE;
        if ((r_red_snap >= RED_THRESH) && (r_red_snap > r_blue_snap)) begin
            w_decision = c_RES_RED;
        end else if ((r_blue_snap >= BLUE_THRESH) && (r_blue_snap > r_red_snap)) begin
            w_decision = c_RES_BLUE;
        end
    end

`ifdef FRAME_VOTE_EN
    localparam int c_VOTE_W = $clog2(VOTE_FRAMES + 1);

    logic [c_VOTE_W-1:0] r_vote_cnt;
    logic [c_VOTE_W-1:0] w_vote_cnt_next;
    logic [1:0]          r_vote_cand;
    logic                w_vote_hold;
    logic                w_vote_commit;

    // A decision matching the published result cancels any pending vote;
    // before the first commit every decision is a candidate.
    always_comb begin
        w_vote_hold     = RESULT_VALID && (w_decision == RESULT);
        w_vote_cnt_next = ((r_vote_cnt != '0) && (w_decision == r_vote_cand))
                          ? r_vote_cnt + c_VOTE_W'(1) : c_VOTE_W'(1);
        w_vote_commit   = !w_vote_hold && (w_vote_cnt_next == c_VOTE_W'(VOTE_FRAMES));
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_vote_cnt  <= '0;
            r_vote_cand <= c_RES_NONE;
        end else if (r_state == c_DECIDE) begin
            if (w_vote_hold || w_vote_commit) begin
                r_vote_cnt <= '0;
            end else begin
                r_vote_cnt  <= w_vote_cnt_next;
                r_vote_cand <= w_decision;
            end
        end
    end
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            RESULT       <= c_RES_NONE;
            RESULT_VALID <= 1'b0;
            RED_COUNT    <= '0;
            BLUE_COUNT   <= '0;
            FRAME_DONE   <= 1'b0;
        end else begin
            FRAME_DONE <= 1'b0;
            if (r_state == c_DECIDE) begin
                FRAME_DONE <= 1'b1;
                RED_COUNT  <= r_red_snap;
                BLUE_COUNT <= r_blue_snap;
`ifdef FRAME_VOTE_EN
                if (w_vote_commit) begin
                    RESULT       <= w_decision;
                    RESULT_VALID <= 1'b1;
                end
`else
                RESULT       <= w_decision;
                RESULT_VALID <= 1'b1;
`endif
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_color_classifier.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_color_classifier
// Description : Directed bench for frame_color_classifier; frame outcomes are
//               queued when a frame ends and compared when FRAME_DONE fires.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_color_classifier;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [7:0]  PIXEL_IN;
    logic [9:0]  VGA_PIXEL_X;
    logic [9:0]  VGA_PIXEL_Y;
    logic        VGA_VSYNC_NEG;
    logic [1:0]  RESULT;
    logic        RESULT_VALID;
    logic [14:0] RED_COUNT;
    logic [14:0] BLUE_COUNT;
    logic        FRAME_DONE;

    frame_color_classifier dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .PIXEL_IN      (PIXEL_IN),
        .VGA_PIXEL_X   (VGA_PIXEL_X),
        .VGA_PIXEL_Y   (VGA_PIXEL_Y),
        .VGA_VSYNC_NEG (VGA_VSYNC_NEG),
        .RESULT        (RESULT),
        .RESULT_VALID  (RESULT_VALID),
        .RED_COUNT     (RED_COUNT),
        .BLUE_COUNT    (BLUE_COUNT),
        .FRAME_DONE    (FRAME_DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [1:0]  res;
        logic        valid;
        logic [14:0] red;
        logic [14:0] blue;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int         m_red, m_blue;
    bit         m_armed;
    logic [1:0] m_result;
    bit         m_valid;
    logic [1:0] m_cand;
    int         m_cnt;
    int         prev_x, prev_y;
    logic [7:0] prev_c;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] decide(input int r, input int b);
        if (r >= 2000 && r > b) return 2'b01;
        if (b >= 2000 && b > r) return 2'b10;
        return 2'b00;
    endfunction

    // Drive address (x,y) now; the data word for the previous address is
    // presented at the same time, mirroring a 1-cycle memory read.
    task automatic present(input int x, input int y, input logic [7:0] c);
        if (m_armed && prev_x < 176 && prev_y < 144) begin
            if (prev_c[7:5] >= 3'd5 && prev_c[4:2] <= 3'd2 && prev_c[1:0] == 2'd0) m_red++;
            if (prev_c[1:0] >= 2'd2 && prev_c[4:2] <= 3'd2 && prev_c[7:5] <= 3'd2) m_blue++;
        end
        VGA_PIXEL_X = 10'(x);
        VGA_PIXEL_Y = 10'(y);
        PIXEL_IN    = prev_c;
        prev_x = x;
        prev_y = y;
        prev_c = c;
    endtask

    task automatic pix(input int x, input int y, input logic [7:0] c);
        present(x, y, c);
        tick();
    endtask

    task automatic frame_fill(input int nred, input int nblue);
        for (int i = 0; i < nred + nblue; i++)
            pix(i % 176, i / 176, (i < nred) ? 8'hE0 : 8'h03);
    endtask

    task automatic model_reset();
        m_red = 0; m_blue = 0; m_armed = 0;
        m_result = 2'b00; m_valid = 0; m_cand = 2'b00; m_cnt = 0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        present(600, 600, 8'h00);
        tick();
        RESET = 1'b0;
        model_reset();
        check("rst_result", 32'(RESULT), 0);
        check("rst_valid", 32'(RESULT_VALID), 0);
        check("rst_red", 32'(RED_COUNT), 0);
        check("rst_blue", 32'(BLUE_COUNT), 0);
        check("rst_done", 32'(FRAME_DONE), 0);
    endtask

    task automatic vsync_edge();
        exp_t       e;
        bit         exp_done;
        logic [1:0] d;
        present(600, 600, 8'h00);
        VGA_VSYNC_NEG = 1'b0;
        exp_done = m_armed;
        if (m_armed) begin
            d = decide(m_red, m_blue);
`ifdef FRAME_VOTE_EN
            if (m_valid && d == m_result) m_cnt = 0;
            else begin
                if (m_cnt != 0 && d == m_cand) m_cnt++;
                else begin m_cand = d; m_cnt = 1; end
                if (m_cnt == 3) begin m_result = d; m_valid = 1; m_cnt = 0; end
            end
`else
            m_result = d;
            m_valid  = 1;
`endif
            e.res = m_result; e.valid = m_valid;
            e.red = 15'(m_red); e.blue = 15'(m_blue);
            sb.push_back(e);
        end
        m_armed = 1; m_red = 0; m_blue = 0;
        tick();
        check("done_early", 32'(FRAME_DONE), 0);
        PIXEL_IN = 8'h00;
        tick();
        check("frame_done", 32'(FRAME_DONE), 32'(exp_done));
        if (exp_done) begin
            e = sb.pop_front();
            check("result", 32'(RESULT), 32'(e.res));
            check("result_valid", 32'(RESULT_VALID), 32'(e.valid));
            check("red_count", 32'(RED_COUNT), 32'(e.red));
            check("blue_count", 32'(BLUE_COUNT), 32'(e.blue));
        end
        tick();
        check("done_pulse_end", 32'(FRAME_DONE), 0);
        VGA_VSYNC_NEG = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        model_reset();
        prev_x = 600; prev_y = 600; prev_c = 8'h00;
        RESET = 1'b1;
        VGA_VSYNC_NEG = 1'b1;
        VGA_PIXEL_X = 10'd600;
        VGA_PIXEL_Y = 10'd600;
        PIXEL_IN = 8'h00;
        repeat (3) tick();
        do_reset();
        tick();

        // First edge after reset only arms the classifier
        frame_fill(100, 0);
        vsync_edge();

        frame_fill(25344, 0);          // full red frame
        vsync_edge();
        frame_fill(0, 25344);          // full blue frame
        vsync_edge();
        frame_fill(3000, 2500);
        vsync_edge();
        frame_fill(1500, 1500);        // below threshold
        vsync_edge();
        frame_fill(2500, 2500);        // tie
        vsync_edge();

        // Red only outside the window, including X=176 and Y=144 exactly
        for (int i = 0; i < 40; i++) pix(176 + i, 5, 8'hE0);
        for (int i = 0; i < 40; i++) pix(i, 144 + (i % 3), 8'hE0);
        pix(10, 10, 8'h00);
        vsync_edge();

        // Data after address X=175 counts, after X=176 does not
        pix(175, 0, 8'hE0);
        pix(176, 0, 8'hE0);
        pix(600, 600, 8'h00);
        vsync_edge();

        // Mid-frame reset discards partial counts and re-arms
        frame_fill(10000, 0);
        do_reset();
        frame_fill(500, 0);
        vsync_edge();
        frame_fill(2000, 0);           // exactly at threshold
        vsync_edge();

`ifdef FRAME_VOTE_EN
        do_reset();
        vsync_edge();
        frame_fill(2000, 0); vsync_edge();
        frame_fill(2000, 0); vsync_edge();
        frame_fill(0, 2000); vsync_edge();
        frame_fill(2000, 0); vsync_edge();
        frame_fill(2000, 0); vsync_edge();
        check("vote_pending", 32'(RESULT), 0);
        frame_fill(2000, 0); vsync_edge();
        check("vote_commit", 32'(RESULT), 1);
`endif

        check("scoreboard_empty", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
